pc_fetch_ctrl: RTL and testbench

//  Fetch-stage PC controller sitting directly downstream of pc_branch: it consumes
//  the taken/redirect decision (pc_sel) plus target, owns the PC register, issues

---
 rtl/riscv_pkg.sv | 18 +
 rtl/pc_next_mux.sv | 23 ++
 rtl/pc_fetch_ctrl.sv | 145 ++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared front-end definitions: fetch FSM states, instruction constants and a target alignment helper.
package riscv_pkg;

    localparam int          ILEN      = 32;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT
    } fetch_state_e;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection for the fetch stage: redirect beats stall, stall beats sequential advance.
module pc_next_mux #(
    parameter int AW = 32
) (
    input  logic [AW-1:0] pc_i,
    input  logic          redirect_i,
    input  logic [AW-1:0] target_i,
    input  logic          stall_i,
    input  logic          advance_i,
    output logic [AW-1:0] pc_next_o
);

    always_comb begin
        pc_next_o = pc_i;
        if (redirect_i) begin
            pc_next_o = target_i;
        end else if (advance_i && !stall_i) begin
            // wraps modulo 2^AW with no indication
            pc_next_o = pc_i + AW'(4);
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC controller: owns the PC, issues single-outstanding imem requests, presents
// instructions to IF/ID and flushes the front pipe on redirect. Optional FETCH_MISALIGN_TRAP_EN.
module pc_fetch_ctrl
    import riscv_pkg::*;
#(
    parameter int          AW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            br_valid_i,
    input  logic            pc_sel_i,
    input  logic [AW-1:0]   pc_target_i,
    output logic            imem_req_o,
    output logic [AW-1:0]   imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [ILEN-1:0] imem_rdata_i,
    output logic            if_valid_o,
    output logic [AW-1:0]   if_pc_o,
    output logic [ILEN-1:0] if_instr_o,
    output logic            flush_o,
    output logic            misalign_o
);

    fetch_state_e    state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic            drop_q, drop_d;
    logic [AW-1:0]   if_pc_q, if_pc_d;
    logic [ILEN-1:0] if_instr_q, if_instr_d;

    logic            redirect;
    logic            load_redirect;
    logic            misalign_hit;
    logic            halt;
    logic            advance;
    logic [AW-1:0]   target_load;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    assign halt          = misalign_q;
    // once halted, later redirects are ignored until reset
    assign redirect      = br_valid_i & pc_sel_i & ~misalign_q;
    assign misalign_hit  = redirect & is_misaligned(pc_target_i[1:0]);
    assign target_load   = pc_target_i;
    assign misalign_o    = misalign_q;
`else
    assign halt          = 1'b0;
    assign redirect      = br_valid_i & pc_sel_i;
    assign misalign_hit  = 1'b0;
    assign target_load   = pc_target_i & ~AW'(3);
    assign misalign_o    = 1'b0;
`endif

    assign load_redirect = redirect & ~misalign_hit;
    assign advance       = (state_q == S_OUT) & ~redirect;

    pc_next_mux #(.AW(AW)) u_pc_next_mux (
        .pc_i       (pc_q),
        .redirect_i (load_redirect),
        .target_i   (target_load),
        .stall_i    (stall_i),
        .advance_i  (advance),
        .pc_next_o  (pc_d)
    );

    always_comb begin
        state_d    = state_q;
        drop_d     = drop_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!halt) state_d = S_REQ;
            end
            S_REQ: begin
                // an accepted request is still in flight, so a redirect must discard its reply
                if (imem_gnt_i) begin
                    state_d = S_WAIT;
                    if (redirect) drop_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    drop_d = 1'b0;
                    if (drop_q || redirect) begin
                        state_d = S_REQ;
                    end else begin
                        state_d    = S_OUT;
                        if_pc_d    = pc_q;
                        if_instr_d = imem_rdata_i;
                    end
                end else if (redirect) begin
                    drop_d = 1'b1;
                end
            end
            S_OUT: begin
                if (redirect || !stall_i) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        if (misalign_hit) begin
            state_d    = S_IDLE;
            drop_d     = 1'b0;
            misalign_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            drop_q     <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_q     <= drop_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign imem_req_o  = (state_q == S_REQ);
    assign imem_addr_o = pc_q;
    assign if_valid_o  = (state_q == S_OUT) & ~redirect;
    assign if_pc_o     = if_pc_q;
    assign if_instr_o  = if_instr_q;
    assign flush_o     = redirect;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a small imem responder (configurable response latency).
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_i, stall_i, br_valid_i, pc_sel_i;
    logic [31:0] pc_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        if_valid_o;
    logic [31:0] if_pc_o, if_instr_o;
    logic        flush_o, misalign_o;

    int n_chk = 0;
    int n_err = 0;

    pc_fetch_ctrl dut (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .br_valid_i(br_valid_i),
        .pc_sel_i(pc_sel_i), .pc_target_i(pc_target_i), .imem_req_o(imem_req_o),
        .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i(imem_rdata_i), .if_valid_o(if_valid_o), .if_pc_o(if_pc_o),
        .if_instr_o(if_instr_o), .flush_o(flush_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    // imem responder: grants any request, answers after extra_lat further cycles
    logic        pend = 1'b0;
    logic        gnt_en = 1'b1;
    int          lat_cnt = 0;
    int          extra_lat = 0;
    logic [31:0] paddr = '0;
    logic [31:0] gnt_log[$];

    always @(negedge clk) begin
        imem_rvalid_i = 1'b0;
        if (pend) begin
            if (lat_cnt == 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = 32'hA000_0000 | paddr;
                pend          = 1'b0;
            end else begin
                lat_cnt--;
            end
        end
        imem_gnt_i = imem_req_o & gnt_en;
        if (imem_gnt_i) begin
            pend    = 1'b1;
            paddr   = imem_addr_o;
            lat_cnt = extra_lat;
            gnt_log.push_back(imem_addr_o);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    int nlog;

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; br_valid_i = 1'b0; pc_sel_i = 1'b0; pc_target_i = '0;
        repeat (3) cyc();
        chk("rst_req", imem_req_o, 0);
        chk("rst_valid", if_valid_o, 0);
        chk("rst_pc", if_pc_o, 0);
        chk("rst_instr", if_instr_o, 0);
        chk("rst_flush", flush_o, 0);
        chk("rst_misalign", misalign_o, 0);
        rst_i = 1'b0;

        // sequential fetch, zero-wait memory: one instruction every 3 cycles
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk("seq_valid", if_valid_o, (i % 3) == 2);
            if (i % 3 == 2) begin
                chk("seq_pc", if_pc_o, (i / 3) * 4);
                chk("seq_instr", if_instr_o, 32'hA000_0000 | ((i / 3) * 4));
            end
        end
        chk("seq_ngnt", gnt_log.size(), 3);
        chk("seq_addr0", gnt_log[0], 32'h0);
        chk("seq_addr1", gnt_log[1], 32'h4);
        chk("seq_addr2", gnt_log[2], 32'h8);

        // stall in S_OUT holds the presented instruction
        stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall_valid", if_valid_o, 1);
            chk("stall_pc", if_pc_o, 32'h8);
            chk("stall_instr", if_instr_o, 32'hA000_0008);
            chk("stall_req", imem_req_o, 0);
        end
        chk("stall_ngnt", gnt_log.size(), 3);
        stall_i = 1'b0;
        extra_lat = 2;

        // redirect while waiting; the late response must be dropped
        cyc();
        chk("wait_req", imem_req_o, 1);
        chk("wait_addr", imem_addr_o, 32'hC);
        extra_lat = 0;
        cyc();
        br_valid_i = 1'b1; pc_sel_i = 1'b1; pc_target_i = 32'h100;
        #1;
        chk("redir_flush", flush_o, 1);
        chk("redir_valid", if_valid_o, 0);
        cyc();
        br_valid_i = 1'b0; pc_sel_i = 1'b0;
        #1;
        chk("redir_flush_off", flush_o, 0);
        chk("redir_noreq", imem_req_o, 0);
        cyc();
        chk("drop_valid", if_valid_o, 0);
        cyc();
        chk("drop_valid2", if_valid_o, 0);
        chk("drop_req", imem_req_o, 1);
        chk("drop_addr", imem_addr_o, 32'h100);
        cyc();
        cyc();
        chk("tgt_valid", if_valid_o, 1);
        chk("tgt_pc", if_pc_o, 32'h100);
        chk("tgt_instr", if_instr_o, 32'hA000_0100);

        // redirect and stall together: redirect wins
        stall_i = 1'b1; br_valid_i = 1'b1; pc_sel_i = 1'b1; pc_target_i = 32'h200;
        #1;
        chk("rs_flush", flush_o, 1);
        chk("rs_valid", if_valid_o, 0);
        cyc();
        stall_i = 1'b0; br_valid_i = 1'b0; pc_sel_i = 1'b0;
        #1;
        chk("rs_req", imem_req_o, 1);
        chk("rs_addr", imem_addr_o, 32'h200);
        chk("rs_flush_off", flush_o, 0);
        cyc();
        cyc();
        chk("rs_out_pc", if_pc_o, 32'h200);

        // unqualified pc_sel is ignored
        br_valid_i = 1'b0; pc_sel_i = 1'bx; pc_target_i = 32'h300;
        #1;
        chk("nq_flush", flush_o, 0);
        chk("nq_valid", if_valid_o, 1);
        cyc();
        chk("nq_addr", imem_addr_o, 32'h204);
        cyc();
        cyc();
        chk("nq_pc", if_pc_o, 32'h204);
        pc_sel_i = 1'b0;

        // misaligned redirect target
        br_valid_i = 1'b1; pc_sel_i = 1'b1; pc_target_i = 32'h102;
        #1;
        chk("mis_flush", flush_o, 1);
        nlog = gnt_log.size();
        cyc();
        br_valid_i = 1'b0; pc_sel_i = 1'b0;
        #1;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_flag", misalign_o, 1);
        chk("mis_req", imem_req_o, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("mis_halt_req", imem_req_o, 0);
            chk("mis_hold", misalign_o, 1);
        end
        chk("mis_ngnt", gnt_log.size(), nlog);
`else
        chk("mis_flag", misalign_o, 0);
        chk("mis_req", imem_req_o, 1);
        chk("mis_addr", imem_addr_o, 32'h100);
        cyc();
        cyc();
        chk("mis_pc", if_pc_o, 32'h100);
`endif

        // reset, then redirect on an accepted request and PC wrap
        rst_i = 1'b1;
        cyc();
        cyc();
        chk("rst2_misalign", misalign_o, 0);
        rst_i = 1'b0;
        cyc();
        chk("wr_req", imem_req_o, 1);
        chk("wr_addr0", imem_addr_o, 32'h0);
        br_valid_i = 1'b1; pc_sel_i = 1'b1; pc_target_i = 32'hFFFF_FFFC;
        #1;
        chk("wr_flush", flush_o, 1);
        cyc();
        br_valid_i = 1'b0; pc_sel_i = 1'b0;
        #1;
        chk("wr_wait", imem_req_o, 0);
        cyc();
        chk("wr_drop_valid", if_valid_o, 0);
        chk("wr_req_tgt", imem_addr_o, 32'hFFFF_FFFC);
        cyc();
        cyc();
        chk("wr_out_pc", if_pc_o, 32'hFFFF_FFFC);
        cyc();
        chk("wr_wrap_addr", imem_addr_o, 32'h0);
        chk("wr_wrap_req", imem_req_o, 1);

        // reset with a response in flight; the late rvalid is ignored
        rst_i = 1'b1;
        cyc();
        chk("mr_req", imem_req_o, 0);
        chk("mr_valid", if_valid_o, 0);
        rst_i = 1'b0;
        gnt_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("mr_hold_req", imem_req_o, 1);
            chk("mr_hold_addr", imem_addr_o, 32'h0);
            chk("mr_hold_valid", if_valid_o, 0);
        end
        gnt_en = 1'b1;
        cyc();
        cyc();
        cyc();
        chk("mr_out_valid", if_valid_o, 1);
        chk("mr_out_pc", if_pc_o, 32'h0);
        chk("mr_out_instr", if_instr_o, 32'hA000_0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
